// File: rtl/alu_result_display.sv
// Four-digit multiplexed seven-segment display for ALU results (add/sub/mul/div).
// Build option: define LEADING_ZERO_BLANK_EN to blank a zero tens digit for ADD/MUL.
module alu_result_display #(
    parameter int CLKS_PER_DIGIT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] result,
    input  logic       flag,
    input  logic [1:0] op,
    input  logic       result_valid,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int CW = $clog2(CLKS_PER_DIGIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_DIGIT - 1);

    // Symbol codes: 0..15 are numeric values (10..15 render as 'E').
    localparam logic [4:0] SYM_BLANK = 5'd16;
    localparam logic [4:0] SYM_DASH  = 5'd17;
    localparam logic [4:0] SYM_E     = 5'd18;
    localparam logic [4:0] SYM_R     = 5'd19;
    localparam logic [4:0] SYM_C     = 5'd20;
    localparam logic [4:0] SYM_O     = 5'd21;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [3:0]    res_q;
    logic          flag_q;
    logic [1:0]    op_q;
    logic          shown_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic [4:0]    sym [4];
    logic [4:0]    sel_sym;
    logic [3:0]    ones;
    logic [3:0]    tens;
    logic [3:0]    neg_mag;

    function automatic logic [6:0] glyph(input logic [4:0] s);
        logic [6:0] g;
        case (s)
            5'd0:     g = 7'b1000000;
            5'd1:     g = 7'b1111001;
            5'd2:     g = 7'b0100100;
            5'd3:     g = 7'b0110000;
            5'd4:     g = 7'b0011001;
            5'd5:     g = 7'b0010010;
            5'd6:     g = 7'b0000010;
            5'd7:     g = 7'b1111000;
            5'd8:     g = 7'b0000000;
            5'd9:     g = 7'b0010000;
            SYM_DASH: g = 7'b0111111;
            SYM_R:    g = 7'b0101111;
            SYM_C:    g = 7'b1000110;
            SYM_O:    g = 7'b0100011;
            SYM_E,
            5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15:
                      g = 7'b0000110;
            default:  g = 7'b1111111;
        endcase
        return g;
    endfunction

    assign ones    = (res_q >= 4'd10) ? (res_q - 4'd10) : res_q;
    assign tens    = (res_q >= 4'd10) ? 4'd1 : 4'd0;
    assign neg_mag = 4'd0 - res_q;

    always_comb begin
        sym[0] = SYM_BLANK;
        sym[1] = SYM_BLANK;
        sym[2] = SYM_BLANK;
        sym[3] = SYM_BLANK;
        case (op_q)
            OP_ADD, OP_MUL: begin
                sym[0] = {1'b0, ones};
`ifdef LEADING_ZERO_BLANK_EN
                sym[1] = (tens == 4'd0) ? SYM_BLANK : {1'b0, tens};
`else
                sym[1] = {1'b0, tens};
`endif
                if (flag_q) begin
                    sym[3] = (op_q == OP_ADD) ? SYM_C : SYM_O;
                end
            end
            OP_SUB: begin
                // A set flag means the result is a negative two's-complement value.
                if (flag_q) begin
                    sym[0] = {1'b0, neg_mag};
                    sym[1] = SYM_DASH;
                end else begin
                    sym[0] = {3'b000, res_q[1:0]};
                end
            end
            default: begin
                if (flag_q) begin
                    sym[3] = SYM_E;
                    sym[2] = SYM_R;
                    sym[1] = SYM_R;
                end else begin
                    sym[2] = {3'b000, res_q[1:0]};
                    sym[1] = SYM_R;
                    sym[0] = {3'b000, res_q[3:2]};
                end
            end
        endcase
    end

    always_comb begin
        sel_sym = shown_q ? sym[dig_q] : SYM_BLANK;
        an_d    = ~(4'b0001 << dig_q);
        seg_d   = glyph(sel_sym);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            dig_d = dig_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            dig_q   <= 2'd0;
            res_q   <= 4'd0;
            flag_q  <= 1'b0;
            op_q    <= 2'd0;
            shown_q <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            if (result_valid) begin
                res_q   <= result;
                flag_q  <= flag;
                op_q    <= op;
                shown_q <= 1'b1;
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: doc/alu_result_display.md
ALU_RESULT_DISPLAY -- requirements
Module: alu_result_display

Interface
REQ-001 SHALL have parameter CLKS_PER_DIGIT, default 50000, clocks each digit is driven before the scan advances (legal range >= 2).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port result  input  4  ALU output code (led_out of the ALU stage).
REQ-005 SHALL have port flag  input  1  ALU carry/borrow/overflow/div0 flag.
REQ-006 SHALL have port op  input  2  ALU opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 SHALL have port result_valid  input  1  capture strobe; result, flag and op are sampled when high at a clock edge.
REQ-008 SHALL have port an  output  4  digit enables, active-low; an[0] is the rightmost digit.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-010 SHALL latch result, flag and op into capture registers, and set a shown bit, on every edge where result_valid=1; holding result_valid high recaptures each cycle.
REQ-011 SHALL hold captured values unchanged while result_valid=0.
REQ-012 SHALL run a prescaler 0..CLKS_PER_DIGIT-1; on wrap, a 2-bit digit index increments, 3 wraps to 0.
REQ-013 SHALL register an and seg each edge: an = one-cold of the current digit index; seg = glyph of that digit from the capture registers. A capture at edge N is visible on seg from edge N+1.
REQ-014 SHALL encode glyphs: blank 1111111, 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, '-' 0111111, E 0000110, r 0101111, C 1000110, o 0100011.
REQ-015 SHALL blank all four digits while shown=0.
REQ-016 ADD (op=00): d0 = ones of result, d1 = tens, d2 blank; d3 = 'C' if flag=1, else blank.
REQ-017 SUB (op=01): flag=0: d0 = result[1:0], d1..d3 blank; flag=1 (negative): d0 = magnitude (two's-complement negation of result, 4-bit wrap), d1 = '-', d2..d3 blank.
REQ-018 MUL (op=10): as ADD, except d3 = 'o' if flag=1.
REQ-019 DIV (op=11), flag=0: d2 = quotient result[1:0], d1 = 'r', d0 = remainder result[3:2], d3 blank.
REQ-020 DIV, flag=1 (divide by zero): d3 = 'E', d2 = 'r', d1 = 'r', d0 blank, regardless of result.
REQ-021 SHALL show 'E' on any digit whose decimal value exceeds 9 (unreachable for legal ALU codes).
REQ-022 SHALL let a capture coinciding with a digit-index advance take effect without skipping or repeating a digit.

Reset
REQ-023 While rst=1: an=1111, seg=1111111, prescaler=0, digit index=0, capture registers=0, shown=0; result_valid is ignored.
REQ-024 On the first edge after rst falls: an=1110 with a blank glyph; reset mid-scan or mid-capture discards all captured data.

Configuration
REQ-025 SHALL honour macro LEADING_ZERO_BLANK_EN: defined, the ADD/MUL tens digit is blank when 0; undefined, it shows '0'.

Verification (bench uses CLKS_PER_DIGIT=4)
REQ-026 Reset, then release -> an 1111 during reset, then 1110, 1101, 1011, 0111, 1110, advancing every 4 clocks; seg 1111111 throughout.
REQ-027 Capture op=00 result=0100 flag=0 -> d0 0011001 ('4'); d1 blank with macro, 1000000 without; d2, d3 blank.
REQ-028 Capture op=01 result=1110 flag=1 -> d0 0100100 ('2'), d1 0111111 ('-'), d2, d3 blank.
REQ-029 Capture op=11 result=0101 flag=0 -> d2 1111001, d1 0101111, d0 1111001, d3 blank.
REQ-030 Capture op=11 result=0000 flag=1 -> d3 'E', d2 'r', d1 'r', d0 blank; then pulse rst -> all blank until the next capture.
REQ-031 Capture op=10 result=0110, then result_valid=0 with inputs changed to 1001 -> display stays '6' for at least two full scans.
